vga_pixel_unpack: RTL and testbench

//  VGA-clock-domain consumer of the DDR3 read data FIFO. It pops 128-bit frame-buffer words,

---
 rtl/vga_pixel_unpack_if.sv | 49 ++++
 rtl/vga_pixel_unpack.sv | 137 +++++++++++++
 tb/tb_vga_pixel_unpack.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_unpack_if.sv
// Pixel request / data FIFO bundle for the VGA pixel unpacker.
// master: timing generator and FIFO side; slave: the unpacker.
interface vga_pixel_unpack_if;
    logic         frame_start;
    logic         pix_req;
    logic         data_fifo_empty;
    logic [127:0] data_fifo_rd_data;
    logic         vga_rd_valid;
    logic         pix_valid;
    logic [7:0]   pix_red;
    logic [7:0]   pix_green;
    logic [7:0]   pix_blue;
    logic         frame_active;
    logic         underflow;
    logic [15:0]  underflow_cnt;
    logic         frame_err;

    modport master (
        output frame_start,
        output pix_req,
        output data_fifo_empty,
        output data_fifo_rd_data,
        input  vga_rd_valid,
        input  pix_valid,
        input  pix_red,
        input  pix_green,
        input  pix_blue,
        input  frame_active,
        input  underflow,
        input  underflow_cnt,
        input  frame_err
    );

    modport slave (
        input  frame_start,
        input  pix_req,
        input  data_fifo_empty,
        input  data_fifo_rd_data,
        output vga_rd_valid,
        output pix_valid,
        output pix_red,
        output pix_green,
        output pix_blue,
        output frame_active,
        output underflow,
        output underflow_cnt,
        output frame_err
    );
endinterface

// File: rtl/vga_pixel_unpack.sv
// Splits 128-bit frame-buffer words into four RGB pixels, one per pixel
// request, tracking frame position, FIFO underflow and frame-sync errors.
module vga_pixel_unpack #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024
) (
    input  logic              vga_clk,
    input  logic              vga_reset,
    vga_pixel_unpack_if.slave bus
);
    localparam int NPIX            = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int WORDS_PER_FRAME = NPIX / 4;
    localparam int CW              = $clog2(NPIX + 1);
    localparam int DW              = $clog2(WORDS_PER_FRAME + 1);
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] pix_cnt_q;
    logic [DW-1:0] debt_q;
    logic [DW-1:0] debt_d;
    logic [127:0]  hold_q;
    logic          miss_q;
    logic          pix_valid_q;
    logic [7:0]    pix_red_q;
    logic [7:0]    pix_green_q;
    logic [7:0]    pix_blue_q;
    logic          underflow_q;
    logic [15:0]   ucnt_q;
    logic          frame_err_q;

    logic [1:0]    lane;
    logic          lane0;
    logic          accept;
    logic          pop_act;
    logic          pop_flush;
    logic          miss_now;
    logic [127:0]  word_sel;
    logic [23:0]   pix_sel;

    assign lane   = pix_cnt_q[1:0];
    assign lane0  = (lane == 2'd0);
    assign accept = (state_q == ACTIVE) && bus.pix_req
                 && !bus.frame_start;

    assign pop_act   = accept && lane0 && !bus.data_fifo_empty;
    assign pop_flush = (state_q == FLUSH) && !bus.frame_start
                    && !bus.data_fifo_empty && (debt_q != '0);
    assign bus.vga_rd_valid = pop_act || pop_flush;

    // Lane 0 bypasses the hold register so the popped word is used at once
    assign miss_now = lane0 ? bus.data_fifo_empty : miss_q;
    assign word_sel = lane0 ? bus.data_fifo_rd_data : hold_q;
    assign pix_sel  = miss_now ? '0 : word_sel[{lane, 5'd0} +: 24];

    assign debt_d = debt_q
                  + DW'(accept && lane0 && bus.data_fifo_empty);

    always_ff @(posedge vga_clk or posedge vga_reset) begin
        if (vga_reset) begin
            state_q     <= IDLE;
            pix_cnt_q   <= '0;
            debt_q      <= '0;
            hold_q      <= '0;
            miss_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_red_q   <= '0;
            pix_green_q <= '0;
            pix_blue_q  <= '0;
            underflow_q <= 1'b0;
            ucnt_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            pix_valid_q <= accept;
            if (bus.frame_start) begin
                // A restart drops any outstanding debt
                if (state_q != IDLE) frame_err_q <= 1'b1;
                state_q     <= ACTIVE;
                pix_cnt_q   <= '0;
                debt_q      <= '0;
                miss_q      <= 1'b0;
                underflow_q <= 1'b0;
                ucnt_q      <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= IDLE;
                    end
                    ACTIVE: begin
                        if (bus.pix_req) begin
                            pix_red_q   <= pix_sel[23:16];
                            pix_green_q <= pix_sel[15:8];
                            pix_blue_q  <= pix_sel[7:0];
                            pix_cnt_q   <= pix_cnt_q + CW'(1);
                            debt_q      <= debt_d;
                            if (lane0) begin
                                miss_q <= bus.data_fifo_empty;
                                if (!bus.data_fifo_empty) begin
                                    hold_q <= bus.data_fifo_rd_data;
                                end else begin
                                    underflow_q <= 1'b1;
                                    if (ucnt_q != 16'hFFFF)
                                        ucnt_q <= ucnt_q + 16'd1;
                                end
                            end
                            if (pix_cnt_q == LAST_PIX)
                                state_q <= (debt_d != '0) ? FLUSH : IDLE;
                        end
                    end
                    FLUSH: begin
                        if (pop_flush) begin
                            debt_q <= debt_q - DW'(1);
                            if (debt_q == DW'(1)) state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.pix_valid     = pix_valid_q;
    assign bus.pix_red       = pix_red_q;
    assign bus.pix_green     = pix_green_q;
    assign bus.pix_blue      = pix_blue_q;
    assign bus.frame_active  = (state_q == ACTIVE);
    assign bus.underflow     = underflow_q;
    assign bus.underflow_cnt = ucnt_q;
    assign bus.frame_err     = frame_err_q;
endmodule

// File: tb/tb_vga_pixel_unpack.sv
// Scoreboard bench for vga_pixel_unpack on an 8x2 frame.
// Pixel n carries blue=n, green=0x30+n, red=0x60+n.
module tb_vga_pixel_unpack;
    localparam int W = 8;
    localparam int H = 2;

    typedef struct {
        logic [23:0] rgb;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    vga_pixel_unpack_if bus ();

    vga_pixel_unpack #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .vga_clk  (clk),
        .vga_reset(rst),
        .bus      (bus)
    );

    logic [127:0] fifo[$];
    exp_t         exp_q[$];
    int           n_pass = 0;
    int           n_total = 0;
    int           pops = 0;
    int           bad_pop = 0;
    int           p0;
    int           pg;

    function automatic logic [23:0] rgb(input int n);
        return {8'(8'h60 + n), 8'(8'h30 + n), 8'(n)};
    endfunction

    function automatic logic [31:0] pxw(input int n);
        return {8'hEE, rgb(n)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    task automatic drive_fifo();
        bus.data_fifo_empty = (fifo.size() == 0);
        bus.data_fifo_rd_data = (fifo.size() == 0)
                              ? {4{32'hDEADBEEF}} : fifo[0];
    endtask

    task automatic push_word(input int base);
        fifo.push_back({pxw(base + 3), pxw(base + 2),
                        pxw(base + 1), pxw(base)});
    endtask

    task automatic load(input int base, input int nwords);
        for (int k = 0; k < nwords; k++) push_word(base + 4 * k);
        drive_fifo();
    endtask

    task automatic flush_model();
        fifo.delete();
        drive_fifo();
    endtask

    // One clock: entered and left at a falling edge
    task automatic step(input logic fs, input logic req,
                        input logic ev, input logic [23:0] e);
        exp_t         x;
        logic         pre;
        logic [127:0] dummy;
        bus.frame_start = fs;
        bus.pix_req     = req;
        if (ev) begin
            x.rgb = e;
            x.due = ncyc + 1;
            exp_q.push_back(x);
        end
        #4;
        pre = bus.vga_rd_valid;
        if (pre && bus.data_fifo_empty) bad_pop++;
        @(posedge clk);
        if (pre) begin
            pops++;
            if (fifo.size() != 0) dummy = fifo.pop_front();
        end
        @(negedge clk);
        bus.frame_start = 1'b0;
        bus.pix_req     = 1'b0;
        drive_fifo();
    endtask

    task automatic pixel(input int n);
        step(1'b0, 1'b1, 1'b1, rgb(n));
    endtask

    task automatic black();
        step(1'b0, 1'b1, 1'b1, 24'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic monitor();
        exp_t        e;
        logic [23:0] got;
        forever begin
            @(negedge clk);
            if (bus.pix_valid) begin
                got = {bus.pix_red, bus.pix_green, bus.pix_blue};
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_pix got=%h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got === e.rgb && ncyc == e.due) n_pass++;
                    else $display("FAIL pixel got=%h@%0d exp=%h@%0d",
                                  got, ncyc, e.rgb, e.due);
                end
            end
        end
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.pix_req     = 1'b0;
        drive_fifo();
        fork
            monitor();
        join_none

        // Reset, with a preloaded FIFO
        load(0, 4);
        @(negedge clk);
        @(negedge clk);
        chk("rst_outs", 64'({bus.pix_valid, bus.frame_active,
            bus.underflow, bus.frame_err, bus.vga_rd_valid,
            bus.pix_red, bus.pix_green, bus.pix_blue,
            bus.underflow_cnt}), 64'd0);
        rst = 1'b0;

        // 1: back-to-back frame
        p0 = pops;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        chk("t1_active", 64'(bus.frame_active), 64'd1);
        for (int n = 0; n < 16; n++) begin
            pixel(n);
            if (n % 4 == 0)
                chk("t1_pop_lane0", 64'(pops - p0), 64'(n / 4 + 1));
        end
        idle(2);
        chk("t1_pops", 64'(pops - p0), 64'd4);
        chk("t1_idle", 64'(bus.frame_active), 64'd0);

        // 2: blanking gap after pixel 6
        load(0, 4);
        p0 = pops;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        for (int n = 0; n < 7; n++) pixel(n);
        pg = pops;
        idle(5);
        chk("t2_gap_pops", 64'(pops - pg), 64'd0);
        chk("t2_gap_active", 64'(bus.frame_active), 64'd1);
        for (int n = 7; n < 16; n++) pixel(n);
        idle(2);
        chk("t2_pops", 64'(pops - p0), 64'd4);

        // 3: underflow on word 2, refill, flush
        load(0, 2);
        p0 = pops;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        for (int n = 0; n < 8; n++) pixel(n);
        for (int n = 0; n < 4; n++) black();
        push_word(8);
        push_word(12);
        drive_fifo();
        for (int n = 8; n < 12; n++) pixel(n);
        idle(3);
        chk("t3_underflow", 64'(bus.underflow), 64'd1);
        chk("t3_ucnt", 64'(bus.underflow_cnt), 64'd1);
        chk("t3_pops", 64'(pops - p0), 64'd4);
        chk("t3_fifo_left", 64'(fifo.size()), 64'd0);
        chk("t3_idle", 64'(bus.frame_active), 64'd0);
        push_word(16);
        drive_fifo();
        pg = pops;
        idle(3);
        chk("t3_no_pop_idle", 64'(pops - pg), 64'd0);
        flush_model();

        // 4: frame_start mid-frame and coincident with pix_req
        load(0, 8);
        p0 = pops;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        chk("t4_err_clear", 64'(bus.frame_err), 64'd0);
        for (int n = 0; n < 5; n++) pixel(n);
        step(1'b1, 1'b0, 1'b0, 24'h0);
        chk("t4_frame_err", 64'(bus.frame_err), 64'd1);
        chk("t4_pops_a", 64'(pops - p0), 64'd2);
        pixel(8);
        pixel(9);
        step(1'b1, 1'b1, 1'b0, 24'h0);
        chk("t4_coinc_pops", 64'(pops - p0), 64'd3);
        for (int n = 12; n < 28; n++) pixel(n);
        idle(2);
        chk("t4_pops_b", 64'(pops - p0), 64'd7);
        chk("t4_err_sticky", 64'(bus.frame_err), 64'd1);
        chk("t4_idle", 64'(bus.frame_active), 64'd0);

        // 6: pix_req in IDLE with a non-empty FIFO
        pg = pops;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 24'h0);
        chk("t6_no_pop", 64'(pops - pg), 64'd0);
        chk("t6_pix_valid", 64'(bus.pix_valid), 64'd0);
        step(1'b1, 1'b0, 1'b0, 24'h0);
        chk("t6_err_kept", 64'({bus.frame_err, bus.frame_active}),
            64'd3);

        // 5: asynchronous reset at lane 2
        flush_model();
        load(0, 4);
        pixel(0);
        pixel(1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_outs", 64'({bus.pix_valid, bus.frame_active,
            bus.underflow, bus.frame_err, bus.vga_rd_valid,
            bus.pix_red, bus.pix_green, bus.pix_blue,
            bus.underflow_cnt}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        flush_model();
        load(0, 4);
        p0 = pops;
        step(1'b1, 1'b0, 1'b0, 24'h0);
        for (int n = 0; n < 16; n++) pixel(n);
        idle(2);
        chk("t5_pops", 64'(pops - p0), 64'd4);
        chk("t5_err_cleared", 64'(bus.frame_err), 64'd0);

        chk("pop_when_empty", 64'(bad_pop), 64'd0);
        chk("exp_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
